spi_flash_loader: RTL and testbench

//  FastClk-domain SPI NOR read engine for the nileswan cart.
//  On Start it issues a flash READ (0x03) command with a 24-bit address and streams

---
 rtl/nileswan_pkg.sv | 20 ++
 rtl/spi_shift_engine.sv | 73 +++++++
 rtl/spi_flash_loader.sv | 174 +++++++++++++++++
 tb/tb_spi_flash_loader.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/nileswan_pkg.sv
// Shared types and constants for the nileswan SPI flash boot loader.
package nileswan_pkg;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_CS_SETUP = 3'd1,
      ST_CMD      = 3'd2,
      ST_ADDR     = 3'd3,
      ST_DATA     = 3'd4,
      ST_CS_HOLD  = 3'd5
   } loader_state_t;

   localparam logic [7:0] FLASH_CMD_READ = 8'h03;
   localparam int         SPI_ADDR_BYTES = 3;

   function automatic logic [8:0] clamp_count(input logic [8:0] req, input logic [8:0] lim);
      return (req > lim) ? lim : req;
   endfunction

endpackage

// File: rtl/spi_shift_engine.sv
// Mode-0 SPI bit-cell generator: shifts one byte out MSB first while capturing one byte in.
module spi_shift_engine #(
   parameter int CLK_DIV = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       clear,
   input  logic       load,
   input  logic [7:0] byte_in,
   input  logic       di,
   output logic [7:0] byte_out,
   output logic       byte_done,
   output logic       byte_end,
   output logic       sclk,
   output logic       mosi
);
   localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   logic          active;
   logic          high;
   logic [CW-1:0] div_cnt;
   logic [2:0]    bit_cnt;
   logic [6:0]    sh_out;
   logic [6:0]    sh_in;
   logic          tick;

   assign tick      = active && (div_cnt == CW'(CLK_DIV - 1));
   // byte_done fires on the 8th capture edge; byte_end on the last cycle of the 8th cell
   assign byte_done = tick && !high && (bit_cnt == 3'd7);
   assign byte_end  = tick && high && (bit_cnt == 3'd7);
   assign byte_out  = {sh_in, di};

   always_ff @(posedge clk) begin
      if (!rst_n || clear) begin
         active  <= 1'b0;
         high    <= 1'b0;
         div_cnt <= '0;
         bit_cnt <= '0;
         sh_out  <= '0;
         sh_in   <= '0;
         sclk    <= 1'b0;
         mosi    <= 1'b0;
      end else if (load) begin
         active  <= 1'b1;
         high    <= 1'b0;
         div_cnt <= '0;
         bit_cnt <= '0;
         sh_out  <= byte_in[6:0];
         mosi    <= byte_in[7];
         sclk    <= 1'b0;
      end else if (tick) begin
         div_cnt <= '0;
         if (!high) begin
            high  <= 1'b1;
            sclk  <= 1'b1;
            sh_in <= {sh_in[5:0], di};
         end else begin
            high <= 1'b0;
            sclk <= 1'b0;
            if (bit_cnt == 3'd7) begin
               active <= 1'b0;
            end else begin
               bit_cnt <= bit_cnt + 3'd1;
               sh_out  <= {sh_out[5:0], 1'b0};
               mosi    <= sh_out[6];
            end
         end
      end else if (active) begin
         div_cnt <= div_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/spi_flash_loader.sv
// SPI NOR READ sequencer: streams little-endian 16-bit words from flash into the boot RAM write port.
module spi_flash_loader
   import nileswan_pkg::*;
#(
   parameter int         CLK_DIV  = 1,
   parameter int         WORDS    = 256,
   parameter logic [7:0] READ_CMD = FLASH_CMD_READ
) (
   input  logic                       FastClk,
   input  logic                       nReset,
   input  logic                       Start,
   input  logic                       Abort,
   input  logic [23:0]                FlashAddr,
   input  logic [8:0]                 WordCount,
   output logic                       Busy,
   output logic                       Done,
   output logic                       SPI_Cs,
   output logic                       SPI_Clk,
   output logic                       SPI_Do,
   input  logic                       SPI_Di,
   output logic                       WrEn,
   output logic [$clog2(WORDS)-1:0]   WrAddr,
   output logic [15:0]                WrData
);
   localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int AW = $clog2(WORDS);

   loader_state_t state;
   logic [CW-1:0] cnt;
   logic [23:0]   addr_q;
   logic [8:0]    words_left;
   logic [1:0]    addr_idx;
   logic          odd;
   logic [7:0]    byte0;
   logic          load;
   logic [7:0]    load_byte;
   logic [7:0]    rx_byte;
   logic          byte_done;
   logic          byte_end;
   logic          cnt_end;

   assign cnt_end = (cnt == CW'(CLK_DIV - 1));

   // Next byte is loaded on the last cycle of the current one so bit cells run back to back
   always_comb begin
      load      = 1'b0;
      load_byte = 8'h00;
      if (!Abort) begin
         case (state)
            ST_CS_SETUP: if (cnt_end) begin
               load      = 1'b1;
               load_byte = READ_CMD;
            end
            ST_CMD: if (byte_end) begin
               load      = 1'b1;
               load_byte = addr_q[23:16];
            end
            ST_ADDR: if (byte_end) begin
               load      = 1'b1;
               load_byte = (addr_idx == 2'd0) ? addr_q[15:8] :
                           (addr_idx == 2'd1) ? addr_q[7:0]  : 8'h00;
            end
            ST_DATA: load = byte_end && !(odd && words_left == 9'd1);
            default: ;
         endcase
      end
   end

   spi_shift_engine #(.CLK_DIV(CLK_DIV)) u_shift (
      .clk      (FastClk),
      .rst_n    (nReset),
      .clear    (Abort),
      .load     (load),
      .byte_in  (load_byte),
      .di       (SPI_Di),
      .byte_out (rx_byte),
      .byte_done(byte_done),
      .byte_end (byte_end),
      .sclk     (SPI_Clk),
      .mosi     (SPI_Do)
   );

   always_ff @(posedge FastClk) begin
      if (!nReset) begin
         state      <= ST_IDLE;
         SPI_Cs     <= 1'b1;
         Busy       <= 1'b0;
         Done       <= 1'b0;
         WrEn       <= 1'b0;
         WrAddr     <= '0;
         WrData     <= '0;
         cnt        <= '0;
         addr_q     <= '0;
         words_left <= '0;
         addr_idx   <= '0;
         odd        <= 1'b0;
         byte0      <= '0;
      end else begin
         Done <= 1'b0;
         WrEn <= 1'b0;
         if (WrEn)
            WrAddr <= (WrAddr == AW'(WORDS - 1)) ? '0 : WrAddr + 1'b1;
         if (Abort) begin
            state  <= ST_IDLE;
            SPI_Cs <= 1'b1;
            Busy   <= 1'b0;
         end else begin
            case (state)
               ST_IDLE: if (Start) begin
                  WrAddr <= '0;
                  if (WordCount == 9'd0) begin
                     Done <= 1'b1;
                  end else begin
                     state      <= ST_CS_SETUP;
                     SPI_Cs     <= 1'b0;
                     Busy       <= 1'b1;
                     cnt        <= '0;
                     addr_q     <= FlashAddr;
                     words_left <= clamp_count(WordCount, 9'(WORDS));
                  end
               end
               ST_CS_SETUP: begin
                  if (cnt_end) state <= ST_CMD;
                  else         cnt   <= cnt + 1'b1;
               end
               ST_CMD: if (byte_end) begin
                  state    <= ST_ADDR;
                  addr_idx <= '0;
               end
               ST_ADDR: if (byte_end) begin
                  if (addr_idx == 2'(SPI_ADDR_BYTES - 1)) begin
                     state <= ST_DATA;
                     odd   <= 1'b0;
                  end else begin
                     addr_idx <= addr_idx + 2'd1;
                  end
               end
               ST_DATA: begin
                  if (byte_done) begin
                     if (odd) begin
                        WrEn   <= 1'b1;
                        WrData <= {rx_byte, byte0};
                     end else begin
                        byte0 <= rx_byte;
                     end
                  end
                  if (byte_end) begin
                     odd <= ~odd;
                     if (odd) begin
                        words_left <= words_left - 9'd1;
                        if (words_left == 9'd1) begin
                           state <= ST_CS_HOLD;
                           cnt   <= '0;
                        end
                     end
                  end
               end
               ST_CS_HOLD: begin
                  if (cnt_end) begin
                     state  <= ST_IDLE;
                     SPI_Cs <= 1'b1;
                     Busy   <= 1'b0;
                     Done   <= 1'b1;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
               default: state <= ST_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_spi_flash_loader.sv
// Bench for spi_flash_loader: two instances (CLK_DIV 1 and 3) against a byte-level flash model.
module tb_spi_flash_loader;

   typedef struct {
      int          g;
      logic [7:0]  a;
      logic [15:0] d;
   } wr_t;

   logic fclk = 1'b0;
   always #5 fclk = ~fclk;

   logic        nrst;
   logic [1:0]  start_v, abort_v;
   logic [1:0]  miso_v = '0;
   logic [23:0] faddr0, faddr1;
   logic [8:0]  wc0, wc1;
   wire  [1:0]  busy_v, done_v, cs_v, sclk_v, mosi_v, wren_v;
   wire  [7:0]  wa0, wa1;
   wire  [15:0] wd0, wd1;

   spi_flash_loader #(.CLK_DIV(1), .WORDS(256), .READ_CMD(8'h03)) dut0 (
      .FastClk(fclk), .nReset(nrst), .Start(start_v[0]), .Abort(abort_v[0]),
      .FlashAddr(faddr0), .WordCount(wc0), .Busy(busy_v[0]), .Done(done_v[0]),
      .SPI_Cs(cs_v[0]), .SPI_Clk(sclk_v[0]), .SPI_Do(mosi_v[0]), .SPI_Di(miso_v[0]),
      .WrEn(wren_v[0]), .WrAddr(wa0), .WrData(wd0));

   spi_flash_loader #(.CLK_DIV(3), .WORDS(256), .READ_CMD(8'h03)) dut1 (
      .FastClk(fclk), .nReset(nrst), .Start(start_v[1]), .Abort(abort_v[1]),
      .FlashAddr(faddr1), .WordCount(wc1), .Busy(busy_v[1]), .Done(done_v[1]),
      .SPI_Cs(cs_v[1]), .SPI_Clk(sclk_v[1]), .SPI_Do(mosi_v[1]), .SPI_Di(miso_v[1]),
      .WrEn(wren_v[1]), .WrAddr(wa1), .WrData(wd1));

   // Flash model and bus monitor: rx[g][k] is the k-th byte the flash returns after the header
   logic [7:0]  rx [2][1024];
   int          bitn[2], cslow[2], donecnt[2], clkbad[2], mosibad[2], run[2], highs[2];
   logic [31:0] hdr[2];
   logic [1:0]  pcs = 2'b11;
   logic [1:0]  psclk = 2'b00;
   wr_t         wlog[$];

   always @(negedge fclk) begin
      for (int g = 0; g < 2; g++) begin
         int         dv, k;
         logic [7:0] b;
         wr_t        w;
         dv = (g == 0) ? 1 : 3;
         if (!cs_v[g]) cslow[g]++;
         if (done_v[g]) donecnt[g]++;
         if (wren_v[g]) begin
            w.g = g;
            w.a = (g == 0) ? wa0 : wa1;
            w.d = (g == 0) ? wd0 : wd1;
            wlog.push_back(w);
         end
         if (pcs[g] && !cs_v[g]) begin
            bitn[g]  = 0;
            highs[g] = 0;
            run[g]   = 1;
         end else if (!cs_v[g]) begin
            if (sclk_v[g] != psclk[g]) begin
               if (psclk[g] && run[g] != dv) clkbad[g]++;
               if (!psclk[g] && highs[g] > 0 && run[g] != dv) clkbad[g]++;
               run[g] = 1;
            end else begin
               run[g]++;
            end
            if (!psclk[g] && sclk_v[g]) begin
               if (bitn[g] < 32) hdr[g] = {hdr[g][30:0], mosi_v[g]};
               else if (mosi_v[g]) mosibad[g]++;
               bitn[g]++;
               highs[g]++;
               if (bitn[g] >= 32) begin
                  k = bitn[g] - 32;
                  b = rx[g][k / 8];
                  miso_v[g] = b[7 - (k % 8)];
               end
            end
         end
         pcs[g]   = cs_v[g];
         psclk[g] = sclk_v[g];
      end
   end

   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge fclk);
      #1;
   endtask

   task automatic pulse_start(input int g, input logic [23:0] fa, input int w);
      if (g == 0) begin faddr0 = fa; wc0 = 9'(w); end
      else        begin faddr1 = fa; wc1 = 9'(w); end
      start_v[g] = 1'b1;
      tick();
      start_v[g] = 1'b0;
   endtask

   function automatic int exp_cs(input int g, input int n);
      return (2 + 2 * (32 + 16 * n)) * ((g == 0) ? 1 : 3);
   endfunction

   task automatic check_xfer(input string tag, input int g, input logic [23:0] fa, input int wc,
                             input int d0, input int c0, input int w0);
      int n, i;
      n = (wc > 256) ? 256 : wc;
      for (int t = 0; t < exp_cs(g, n) + 50; t++) begin
         if (donecnt[g] != d0) break;
         tick();
      end
      chk({tag, "/done"}, 64'(donecnt[g] - d0), 64'd1);
      chk({tag, "/cs_low"}, 64'(cslow[g] - c0), 64'(exp_cs(g, n)));
      chk({tag, "/hdr"}, 64'(hdr[g]), 64'({8'h03, fa}));
      chk({tag, "/mosi_data"}, 64'(mosibad[g]), 64'd0);
      chk({tag, "/clk_shape"}, 64'(clkbad[g]), 64'd0);
      chk({tag, "/idle"}, 64'({cs_v[g], busy_v[g]}), 64'b10);
      i = 0;
      for (int j = w0; j < wlog.size(); j++) begin
         if (wlog[j].g == g) begin
            chk({tag, "/waddr"}, 64'(wlog[j].a), 64'(i % 256));
            chk({tag, "/wdata"}, 64'(wlog[j].d), 64'({rx[g][2*i+1], rx[g][2*i]}));
            i++;
         end
      end
      chk({tag, "/nwrites"}, 64'(i), 64'(n));
   endtask

   function automatic int writes_since(input int g, input int w0);
      int c = 0;
      for (int j = w0; j < wlog.size(); j++) if (wlog[j].g == g) c++;
      return c;
   endfunction

   initial begin
      int d0, c0, w0;
      logic [23:0] fa;
      int wc, g;

      nrst = 1'b0; start_v = '0; abort_v = '0;
      faddr0 = '0; faddr1 = '0; wc0 = '0; wc1 = '0;
      repeat (3) tick();
      chk("reset/cs", 64'(cs_v), 64'b11);
      chk("reset/busy_done", 64'({busy_v, done_v}), 64'd0);
      chk("reset/clk_do", 64'({sclk_v, mosi_v}), 64'd0);
      chk("reset/wren", 64'(wren_v), 64'd0);
      chk("reset/wport", 64'({wa0, wd0, wa1, wd1}), 64'd0);
      nrst = 1'b1;
      tick();

      // Two words, CLK_DIV=1
      rx[0][0] = 8'hA5; rx[0][1] = 8'h5A; rx[0][2] = 8'h01; rx[0][3] = 8'h80;
      d0 = donecnt[0]; c0 = cslow[0]; w0 = wlog.size();
      pulse_start(0, 24'h012345, 2);
      chk("t1/start_cs_busy", 64'({cs_v[0], busy_v[0]}), 64'b01);
      check_xfer("t1", 0, 24'h012345, 2, d0, c0, w0);

      // One word, CLK_DIV=3
      rx[1][0] = 8'hFF; rx[1][1] = 8'h00;
      d0 = donecnt[1]; c0 = cslow[1]; w0 = wlog.size();
      pulse_start(1, 24'hC0FFEE, 1);
      check_xfer("t2", 1, 24'hC0FFEE, 1, d0, c0, w0);

      // Zero word count
      d0 = donecnt[0]; c0 = cslow[0]; w0 = wlog.size();
      pulse_start(0, 24'h000100, 0);
      chk("t3/done_pulse", 64'({done_v[0], cs_v[0], busy_v[0]}), 64'b110);
      tick();
      chk("t3/done_drop", 64'(done_v[0]), 64'd0);
      repeat (5) tick();
      chk("t3/no_activity", 64'({cslow[0] - c0, writes_since(0, w0)}), 64'd0);

      // Abort in the same cycle as Start
      d0 = donecnt[0]; c0 = cslow[0];
      faddr0 = 24'h111111; wc0 = 9'd3;
      start_v[0] = 1'b1; abort_v[0] = 1'b1;
      tick();
      start_v[0] = 1'b0; abort_v[0] = 1'b0;
      repeat (4) tick();
      chk("abort_start/quiet", 64'({cslow[0] - c0, donecnt[0] - d0}), 64'd0);

      // Abort at 10th data bit of word 1
      for (int i = 0; i < 8; i++) rx[0][i] = 8'($urandom);
      d0 = donecnt[0]; w0 = wlog.size();
      pulse_start(0, 24'h00ABCD, 4);
      for (int t = 0; t < 400; t++) begin
         if (bitn[0] >= 58) break;
         tick();
      end
      chk("t4/reached_bit", 64'(bitn[0] == 58), 64'd1);
      abort_v[0] = 1'b1;
      tick();
      abort_v[0] = 1'b0;
      chk("t4/pins", 64'({cs_v[0], sclk_v[0], mosi_v[0], busy_v[0], wren_v[0]}), 64'b10000);
      repeat (30) tick();
      chk("t4/nwrites", 64'(writes_since(0, w0)), 64'd1);
      chk("t4/waddr", 64'(wlog[w0].a), 64'd0);
      chk("t4/wdata", 64'(wlog[w0].d), 64'({rx[0][1], rx[0][0]}));
      chk("t4/no_done", 64'(donecnt[0] - d0), 64'd0);
      rx[0][0] = 8'($urandom); rx[0][1] = 8'($urandom);
      d0 = donecnt[0]; c0 = cslow[0]; w0 = wlog.size();
      pulse_start(0, 24'h00ABCD, 1);
      check_xfer("t4_restart", 0, 24'h00ABCD, 1, d0, c0, w0);

      // Randomised transfers on both instances
      for (int r = 0; r < 6; r++) begin
         g  = r % 2;
         fa = 24'($urandom);
         wc = int'($urandom_range(1, 4));
         for (int i = 0; i < 2 * wc; i++) rx[g][i] = 8'($urandom);
         d0 = donecnt[g]; c0 = cslow[g]; w0 = wlog.size();
         pulse_start(g, fa, wc);
         check_xfer("rand", g, fa, wc, d0, c0, w0);
      end

      // Oversized count clamps; a second Start while busy is ignored
      for (int i = 0; i < 512; i++) rx[0][i] = 8'($urandom);
      fa = 24'($urandom);
      d0 = donecnt[0]; c0 = cslow[0]; w0 = wlog.size();
      pulse_start(0, fa, 300);
      repeat (500) tick();
      pulse_start(0, ~fa, 7);
      chk("t5/still_busy", 64'(busy_v[0]), 64'd1);
      check_xfer("t5", 0, fa, 300, d0, c0, w0);

      // Synchronous reset during ADDR phase
      d0 = donecnt[0]; w0 = wlog.size();
      pulse_start(0, 24'h123456, 2);
      for (int t = 0; t < 100; t++) begin
         if (bitn[0] >= 16) break;
         tick();
      end
      chk("t6/in_addr", 64'({cs_v[0], bitn[0] >= 16, bitn[0] < 32}), 64'b011);
      nrst = 1'b0;
      tick();
      chk("t6/cs_busy_done", 64'({cs_v[0], busy_v[0], done_v[0]}), 64'b100);
      chk("t6/clk_do_wren", 64'({sclk_v[0], mosi_v[0], wren_v[0]}), 64'd0);
      chk("t6/wport", 64'({wa0, wd0}), 64'd0);
      nrst = 1'b1;
      repeat (20) tick();
      chk("t6/after", 64'({donecnt[0] - d0, writes_since(0, w0)}), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
